// File: rtl/imm_encoder.sv
// imm_encoder: two-stage RISC-V immediate encoder for the program loader path.
// Stage 1 registers the request and evaluates the immediate range check.
// Stage 2 packs the immediate into the instruction template and tracks the
// instruction-memory write address.
// Build option: define IMM_CHECK_EN to build the range/alignment checks;
// without it ImmErr and ErrSticky are tied to 0.
module imm_encoder #(
  parameter int                    WIDTH      = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [1:0]            ImmSrc,
  input  logic [WIDTH-1:0]      ImmIn,
  input  logic [WIDTH-1:0]      BaseInstr,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [WIDTH-1:0]      InstrOut,
  output logic [ADDR_WIDTH-1:0] WrAddr,
  output logic                  ImmErr,
  output logic                  ErrSticky
);

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;

  logic                  v1, v2;
  logic [1:0]            src1;
  logic [WIDTH-1:0]      imm1;
  logic [WIDTH-1:0]      base1;
  logic [WIDTH-1:0]      instr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  adv1, adv2;

  // Scatter the immediate into the selected format's fields; every other
  // template bit passes through untouched.
  function automatic logic [31:0] pack(input logic [1:0]  s,
                                       input logic [31:0] imm,
                                       input logic [31:0] base);
    logic [31:0] w;
    w = base;
    case (s)
      FMT_I: w[31:20] = imm[11:0];
      FMT_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      FMT_B: begin
        w[31]    = imm[12];
        w[7]     = imm[11];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
      end
      default: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
    endcase
    return w;
  endfunction

  // A stage may load when it is empty or its content leaves this edge.
  always_comb begin
    adv2 = !v2 || OutReady;
    adv1 = !v1 || adv2;
  end

  assign InReady  = adv1;
  assign OutValid = v2;
  assign InstrOut = instr_q;
  assign WrAddr   = addr_q;

  // Stage 1: capture the offered request.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      src1  <= FMT_I;
      imm1  <= '0;
      base1 <= '0;
    end else if (adv1) begin
      v1    <= InValid;
      src1  <= ImmSrc;
      imm1  <= ImmIn;
      base1 <= BaseInstr;
    end
  end

  // Stage 2: pack the word; the write address steps on each delivered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2      <= 1'b0;
      instr_q <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) instr_q <= pack(src1, imm1, base1);
      end
      if (v2 && OutReady) addr_q <= addr_q + ADDR_WIDTH'(4);
    end
  end

`ifdef IMM_CHECK_EN
  logic err1, err_q, sticky;

  // Out of range means the bits above the field's sign bit are not all
  // copies of it; B and J targets must also be even.
  function automatic logic range_err(input logic [1:0]  s,
                                     input logic [31:0] imm);
    logic bad;
    case (s)
      FMT_I, FMT_S: bad = !((&imm[31:11]) || !(|imm[31:11]));
      FMT_B:        bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      default:      bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
    endcase
    return bad;
  endfunction

  assign err1 = range_err(src1, imm1);

  // Error flag travels with its word; sticky flag records delivered errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      if (adv2 && v1) err_q <= err1;
      if (v2 && OutReady && err_q) sticky <= 1'b1;
    end
  end

  assign ImmErr    = err_q;
  assign ErrSticky = sticky;
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm1[31:21];
  assign ImmErr        = 1'b0;
  assign ErrSticky     = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed stimulus with a bit-position reference model and
// a per-cycle compare process; a second instance covers address wrap.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid;
  logic [1:0]  ImmSrc;
  logic [31:0] ImmIn;
  logic [31:0] BaseInstr;
  logic        OutReady;

  logic        InReady, OutValid, ImmErr, ErrSticky;
  logic [31:0] InstrOut, WrAddr;
  logic        w_InReady, w_OutValid, w_ImmErr, w_ErrSticky;
  logic [31:0] w_InstrOut;
  logic [3:0]  w_WrAddr;

  imm_encoder #(.WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'd0)) u_dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady),
    .ImmSrc(ImmSrc), .ImmIn(ImmIn), .BaseInstr(BaseInstr),
    .OutValid(OutValid), .OutReady(OutReady), .InstrOut(InstrOut),
    .WrAddr(WrAddr), .ImmErr(ImmErr), .ErrSticky(ErrSticky));

  imm_encoder #(.WIDTH(32), .ADDR_WIDTH(4), .BASE_ADDR(4'd8)) u_wrap (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(w_InReady),
    .ImmSrc(ImmSrc), .ImmIn(ImmIn), .BaseInstr(BaseInstr),
    .OutValid(w_OutValid), .OutReady(OutReady), .InstrOut(w_InstrOut),
    .WrAddr(w_WrAddr), .ImmErr(w_ImmErr), .ErrSticky(w_ErrSticky));

  always #5 clk = ~clk;

`ifdef IMM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct { logic [31:0] instr; logic err; int acc; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] obs_instr[$];
  logic        obs_err[$];
  logic [31:0] obs_addr[$];
  logic [3:0]  obs_waddr[$];
  int          obs_lat[$];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cycle    = 0;
  logic [31:0] m_addr   = 32'd0;
  logic [3:0]  m_waddr  = 4'd8;
  logic        m_sticky = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr, prev_addr;
  logic        prev_err;
  logic        saw_ready_low = 1'b0;
  int          max_held = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Which immediate bit lands in instruction bit p for a format (-1: template).
  function automatic int src_bit(input logic [1:0] f, input int p);
    case (f)
      2'b00: return (p >= 20) ? p - 20 : -1;
      2'b01: return (p >= 25) ? p - 20 : ((p >= 7 && p <= 11) ? p - 7 : -1);
      2'b10: begin
        if (p == 31) return 12;
        if (p >= 25) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        if (p == 7) return 11;
        return -1;
      end
      default: begin
        if (p == 31) return 20;
        if (p >= 21) return p - 20;
        if (p == 20) return 11;
        if (p >= 12) return p;
        return -1;
      end
    endcase
  endfunction

  function automatic logic [31:0] model_pack(input logic [1:0] f, input logic [31:0] imm,
                                             input logic [31:0] base);
    logic [31:0] r;
    r = base;
    for (int p = 0; p < 32; p++) begin
      int s;
      s = src_bit(f, p);
      if (s >= 0) r[p] = imm[s];
    end
    return r;
  endfunction

  function automatic logic model_err(input logic [1:0] f, input logic [31:0] imm);
    longint v;
    logic bad;
    v = longint'($signed(imm));
    case (f)
      2'b00, 2'b01: bad = (v < -2048) || (v > 2047);
      2'b10:        bad = (v < -4096) || (v > 4095) || imm[0];
      default:      bad = (v < -(64'sd1 <<< 20)) || (v >= (64'sd1 <<< 20)) || imm[0];
    endcase
    return CHK && bad;
  endfunction

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic exp_valid;
    exp_t e;
    cycle++;
    if (rst) begin
      exp_q.delete();
      m_addr = 32'd0; m_waddr = 4'd8; m_sticky = 1'b0; prev_stall = 1'b0;
    end else begin
      exp_valid = (exp_q.size() > 0) && (cycle >= exp_q[0].acc + 2);
      check("out_valid", OutValid, exp_valid);
      check("w_out_valid", w_OutValid, exp_valid);
      check("in_ready", InReady, (exp_q.size() < 2) || OutReady);
      check("w_in_ready", w_InReady, (exp_q.size() < 2) || OutReady);
      check("err_sticky", ErrSticky, m_sticky);
      check("w_err_sticky", w_ErrSticky, m_sticky);
      check("wr_addr", WrAddr, m_addr);
      check("w_wr_addr", w_WrAddr, m_waddr);
      if (!InReady) saw_ready_low = 1'b1;
      if (exp_q.size() > max_held) max_held = exp_q.size();
      if (prev_stall && OutValid) begin
        check("stall_instr", InstrOut, prev_instr);
        check("stall_err", ImmErr, prev_err);
        check("stall_addr", WrAddr, prev_addr);
      end
      if (OutValid && exp_valid) begin
        check("instr_out", InstrOut, exp_q[0].instr);
        check("w_instr_out", w_InstrOut, exp_q[0].instr);
        check("imm_err", ImmErr, exp_q[0].err);
        check("w_imm_err", w_ImmErr, exp_q[0].err);
      end
      prev_stall = OutValid && !OutReady;
      prev_instr = InstrOut; prev_err = ImmErr; prev_addr = WrAddr;
      if (OutValid && OutReady && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs_instr.push_back(InstrOut); obs_err.push_back(ImmErr);
        obs_addr.push_back(WrAddr); obs_waddr.push_back(w_WrAddr);
        obs_lat.push_back(cycle - e.acc);
        m_addr   = m_addr + 32'd4;
        m_waddr  = m_waddr + 4'd4;
        m_sticky = m_sticky | e.err;
      end
      if (InValid && InReady) begin
        e.instr = model_pack(ImmSrc, ImmIn, BaseInstr);
        e.err   = model_err(ImmSrc, ImmIn);
        e.acc   = cycle;
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] base);
    int  n;
    logic hs;
    n = 0;
    hs = 1'b0;
    InValid = 1'b1; ImmSrc = s; ImmIn = imm; BaseInstr = base;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = InReady;
      @(posedge clk); #1;
      n++;
    end
    InValid = 1'b0;
    if (!hs) begin
      n_checks++;
      $display("FAIL send_timeout: InReady stayed 0 for %0d cycles", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    OutReady = 1'b1;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d words still pending", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    obs_instr.delete(); obs_err.delete(); obs_addr.delete();
    obs_waddr.delete(); obs_lat.delete();
  endtask

  task automatic check_obs(input int i, input logic [31:0] instr, input logic err,
                           input logic [31:0] addr);
    if (obs_instr.size() > i) begin
      check($sformatf("obs%0d_instr", i), obs_instr[i], instr);
      check($sformatf("obs%0d_err", i), obs_err[i], err);
      check($sformatf("obs%0d_addr", i), obs_addr[i], addr);
    end else begin
      n_checks++;
      $display("FAIL obs%0d_missing: got %0d words expected more than %0d", i, obs_instr.size(), i);
    end
  endtask

  initial begin
    rst = 1'b1; InValid = 1'b0; ImmSrc = 2'b00; ImmIn = '0; BaseInstr = '0; OutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", OutValid, 1'b0);
    check("rst_in_ready", InReady, 1'b1);
    check("rst_instr", InstrOut, 32'h0);
    check("rst_imm_err", ImmErr, 1'b0);
    check("rst_sticky", ErrSticky, 1'b0);
    check("rst_addr", WrAddr, 32'h0);
    check("rst_w_addr", w_WrAddr, 4'd8);
    @(posedge clk); #1;

    // Encoding of each format plus template masking.
    obs_instr.delete(); obs_err.delete(); obs_addr.delete(); obs_lat.delete(); obs_waddr.delete();
    send(2'b00, 32'hFFFFFFFB, 32'h00000013);
    send(2'b01, 32'h000007F4, 32'h00002023);
    send(2'b10, 32'hFFFFF000, 32'h00000063);
    send(2'b11, 32'h00000002, 32'h0000006F);
    send(2'b00, 32'h00000000, 32'hFFF00013);
    drain();
    check_obs(0, 32'hFFB00013, 1'b0, 32'd0);
    check_obs(1, 32'h7E002A23, 1'b0, 32'd4);
    check_obs(2, 32'h80000063, 1'b0, 32'd8);
    check_obs(3, 32'h0020006F, 1'b0, 32'd12);
    check_obs(4, 32'h00000013, 1'b0, 32'd16);
    if (obs_lat.size() > 0) check("latency", obs_lat[0], 32'd2);

    // Error path and range boundaries.
    do_reset();
    send(2'b00, 32'h00000800, 32'h00000013);
    send(2'b10, 32'h00000003, 32'h00000063);
    send(2'b00, 32'hFFFFF7FF, 32'h00000013);
    send(2'b11, 32'h00100000, 32'h0000006F);
    send(2'b11, 32'h000FFFFE, 32'h0000006F);
    send(2'b00, 32'h000007FF, 32'h00000013);
    send(2'b00, 32'hFFFFF800, 32'h00000013);
    drain();
    check_obs(0, 32'h80000013, CHK, 32'd0);
    check_obs(1, 32'h00000163, CHK, 32'd4);
    check_obs(2, 32'h7FF00013, CHK, 32'd8);
    check_obs(3, 32'h8000006F, CHK, 32'd12);
    check_obs(4, 32'h7FFFF06F, 1'b0, 32'd16);
    check_obs(5, 32'h7FF00013, 1'b0, 32'd20);
    check_obs(6, 32'h80000013, 1'b0, 32'd24);
    check("sticky_after_errs", ErrSticky, CHK);

    // Backpressure: four words offered while the output is stalled.
    do_reset();
    saw_ready_low = 1'b0; max_held = 0;
    OutReady = 1'b0;
    fork
      begin
        send(2'b00, 32'd1, 32'h00000013);
        send(2'b00, 32'd2, 32'h00000013);
        send(2'b00, 32'd3, 32'h00000013);
        send(2'b00, 32'd4, 32'h00000013);
      end
      begin
        repeat (5) @(posedge clk);
        #1 OutReady = 1'b1;
      end
    join
    drain();
    check("bp_ready_low", saw_ready_low, 1'b1);
    check("bp_max_held", max_held, 32'd2);
    check_obs(0, 32'h00100013, 1'b0, 32'd0);
    check_obs(1, 32'h00200013, 1'b0, 32'd4);
    check_obs(2, 32'h00300013, 1'b0, 32'd8);
    check_obs(3, 32'h00400013, 1'b0, 32'd12);

    // Address wrap on the 4-bit instance, then reset with words in flight.
    do_reset();
    send(2'b00, 32'd5, 32'h00000013);
    send(2'b00, 32'h00000800, 32'h00000013);
    send(2'b00, 32'd6, 32'h00000013);
    drain();
    check("wrap_count", obs_waddr.size(), 32'd3);
    if (obs_waddr.size() == 3) begin
      check("wrap_addr0", obs_waddr[0], 4'd8);
      check("wrap_addr1", obs_waddr[1], 4'd12);
      check("wrap_addr2", obs_waddr[2], 4'd0);
    end
    check("wrap_sticky_pre", w_ErrSticky, CHK);
    send(2'b00, 32'h00000800, 32'h00000013);
    send(2'b00, 32'd7, 32'h00000013);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_out_valid", w_OutValid, 1'b0);
      check("flush_w_addr", w_WrAddr, 4'd8);
      check("flush_sticky", w_ErrSticky, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
